// File: rtl/vga_sprite_pipe.sv
// Pixel pipeline stage between the 640x480 timing generator and the VGA pins.
// It latches the sprite position once per frame, generates the sprite ROM address
// and absorbs the ROM read latency. It then composites the sprite over a background
// colour. RGB and syncs leave with the same latency, ROM_LAT+2 cycles.
//
// Ports:
//   pclk, rst            pixel clock, synchronous active-high reset
//   hsync_in, vsync_in   timing-generator syncs
//   valid_in             active-video flag
//   h_cnt, v_cnt         pixel column / line number
//   sprite_x, sprite_y   requested sprite top-left corner (latched once per frame)
//   bg_color             RGB444 background, sampled at the output stage
//   rom_addr, rom_data   sprite ROM address out / RGB444 pixel back
//   hsync, vsync         syncs aligned with the RGB outputs
//   vga_r, vga_g, vga_b  RGB444 outputs
//   frame_tick           one-cycle pulse after a new position is latched
module vga_sprite_pipe #(
  parameter int unsigned SPR_W     = 100,
  parameter int unsigned SPR_H     = 100,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned ADDR_W    = 14,
  parameter bit          SYNC_IDLE = 1'b1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              valid_in,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [11:0]       bg_color,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_tick
);

  localparam logic [9:0]        XMax   = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0]        YMax   = 10'(V_ACTIVE - SPR_H);
  localparam logic [9:0]        VLatch = 10'(V_ACTIVE);
  localparam logic [10:0]       SprW11 = 11'(SPR_W);
  localparam logic [10:0]       SprH11 = 11'(SPR_H);
  localparam logic [ADDR_W-1:0] SprWA  = ADDR_W'(SPR_W);

  logic [9:0]        x_q, y_q;
  logic              tick_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ROM_LAT:0]  area_q, valid_q;
  logic [ROM_LAT+1:0] hs_q, vs_q;
  logic [11:0]       rgb_q;

  logic              latch;
  logic [9:0]        x_clamp, y_clamp;
  logic              in_x, in_y, in_area;
  logic [9:0]        dx10, dy10;
  logic [ADDR_W-1:0] addr_d;
  logic [11:0]       rgb_d;

  // Position is only taken at the first blanking line, so motion never tears a frame.
  always_comb begin
    latch   = (v_cnt == VLatch) && (h_cnt == 10'd0);
    x_clamp = (sprite_x > XMax) ? XMax : sprite_x;
    y_clamp = (sprite_y > YMax) ? YMax : sprite_y;
  end

  // Upper bounds compared at 11 bits so x_q+SPR_W cannot wrap.
  always_comb begin
    in_x    = (h_cnt >= x_q) && ({1'b0, h_cnt} < ({1'b0, x_q} + SprW11));
    in_y    = (v_cnt >= y_q) && ({1'b0, v_cnt} < ({1'b0, y_q} + SprH11));
    in_area = valid_in && in_x && in_y;
    dx10    = h_cnt - x_q;
    dy10    = v_cnt - y_q;
    addr_d  = '0;
    if (in_area) begin
      addr_d = ADDR_W'(dy10) * SprWA + ADDR_W'(dx10);
    end
  end

  // Output compositing: blanking is black, otherwise sprite over background.
  always_comb begin
    rgb_d = 12'h000;
    if (valid_q[ROM_LAT]) begin
      rgb_d = area_q[ROM_LAT] ? rom_data : bg_color;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      tick_q  <= 1'b0;
      addr_q  <= '0;
      area_q  <= '0;
      valid_q <= '0;
      hs_q    <= {(ROM_LAT + 2){SYNC_IDLE}};
      vs_q    <= {(ROM_LAT + 2){SYNC_IDLE}};
      rgb_q   <= '0;
    end else begin
      if (latch) begin
        x_q <= x_clamp;
        y_q <= y_clamp;
      end
      tick_q  <= latch;
      addr_q  <= addr_d;
      // in-area/valid need ROM_LAT+1 stages to meet rom_data at the output register.
      area_q  <= {area_q[ROM_LAT-1:0], in_area};
      valid_q <= {valid_q[ROM_LAT-1:0], valid_in};
      hs_q    <= {hs_q[ROM_LAT:0], hsync_in};
      vs_q    <= {vs_q[ROM_LAT:0], vsync_in};
      rgb_q   <= rgb_d;
    end
  end

  assign rom_addr   = addr_q;
  assign frame_tick = tick_q;
  assign hsync      = hs_q[ROM_LAT+1];
  assign vsync      = vs_q[ROM_LAT+1];
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sprite_pipe.sv
// Directed bench for vga_sprite_pipe: a default instance (ROM_LAT=1) and a ROM_LAT=2
// instance driven by the same inputs. rom_data is driven directly by the bench.
module tb_vga_sprite_pipe;

  logic        pclk = 1'b0;
  logic        rst;
  logic        hsync_in, vsync_in, valid_in;
  logic [9:0]  h_cnt, v_cnt, sprite_x, sprite_y;
  logic [11:0] bg_color, rom_data;

  logic [13:0] rom_addr, rom_addr2;
  logic        hsync, vsync, frame_tick, hsync2, vsync2, frame_tick2;
  logic [3:0]  vga_r, vga_g, vga_b, vga_r2, vga_g2, vga_b2;
  logic [11:0] rgb;

  assign rgb = {vga_r, vga_g, vga_b};

  always #5 pclk = ~pclk;

  vga_sprite_pipe dut (
    .pclk(pclk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .valid_in(valid_in),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .bg_color(bg_color), .rom_addr(rom_addr), .rom_data(rom_data), .hsync(hsync),
    .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick)
  );

  vga_sprite_pipe #(.ROM_LAT(2)) dut2 (
    .pclk(pclk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .valid_in(valid_in),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .bg_color(bg_color), .rom_addr(rom_addr2), .rom_data(rom_data), .hsync(hsync2),
    .vsync(vsync2), .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2), .frame_tick(frame_tick2)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic val);
    h_cnt    = h;
    v_cnt    = v;
    valid_in = val;
  endtask

  task automatic idle();
    pix(10'd700, 10'd500, 1'b0);
  endtask

  task automatic do_latch(input logic [9:0] sx, input logic [9:0] sy);
    sprite_x = sx;
    sprite_y = sy;
    pix(10'd0, 10'd480, 1'b0);
    cyc();
    check("latch_tick", frame_tick, 1);
    idle();
    cyc();
    check("tick_pulse", frame_tick, 0);
  endtask

  // Apply one pixel, check its address, then check its colour two edges later.
  task automatic pixel_chk(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input logic val, input logic [13:0] exp_addr,
                           input logic [11:0] exp_rgb);
    pix(h, v, val);
    cyc();
    check({tag, "_addr"}, rom_addr, exp_addr);
    idle();
    cyc();
    cyc();
    check({tag, "_rgb"}, rgb, exp_rgb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    sprite_x = 10'd0;
    sprite_y = 10'd0;
    bg_color = 12'h123;
    rom_data = 12'hABC;
    pix(10'd0, 10'd0, 1'b1);

    // Reset held with active inputs.
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rst_addr", rom_addr, 0);
      check("rst_rgb", rgb, 0);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_tick", frame_tick, 0);
    end
    rst      = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    idle();
    cyc();
    cyc();
    cyc();

    // Sprite at origin.
    do_latch(10'd0, 10'd0);
    pixel_chk("first", 10'd0, 10'd0, 1'b1, 14'd0, 12'hABC);
    pixel_chk("row0_end", 10'd99, 10'd0, 1'b1, 14'd99, 12'hABC);
    pixel_chk("right_out", 10'd100, 10'd0, 1'b1, 14'd0, 12'h123);
    pixel_chk("mid", 10'd5, 10'd2, 1'b1, 14'd205, 12'hABC);

    // Sprite at (200,100): last pixel then the one just right of it, back to back.
    do_latch(10'd200, 10'd100);
    pixel_chk("left_out", 10'd199, 10'd100, 1'b1, 14'd0, 12'h123);
    pix(10'd299, 10'd199, 1'b1);
    cyc();
    check("last_addr", rom_addr, 9999);
    pix(10'd300, 10'd199, 1'b1);
    cyc();
    check("past_addr", rom_addr, 0);
    idle();
    cyc();
    check("last_rgb", rgb, 12'hABC);
    cyc();
    check("past_rgb", rgb, 12'h123);

    // Clamp to (540,380).
    do_latch(10'd600, 10'd470);
    pixel_chk("clamp_in", 10'd541, 10'd381, 1'b1, 14'd101, 12'hABC);
    pixel_chk("clamp_corner", 10'd639, 10'd479, 1'b1, 14'd9999, 12'hABC);
    pixel_chk("clamp_left", 10'd539, 10'd380, 1'b1, 14'd0, 12'h123);

    // Mid-frame position change must not move the window.
    sprite_x = 10'd0;
    sprite_y = 10'd0;
    pixel_chk("notear_old", 10'd0, 10'd400, 1'b1, 14'd0, 12'h123);
    pixel_chk("notear_win", 10'd541, 10'd381, 1'b1, 14'd101, 12'hABC);

    // Blanking with in-area coordinates.
    pixel_chk("blank", 10'd541, 10'd381, 1'b0, 14'd0, 12'h000);

    // Sync alignment: L=3 for ROM_LAT=1, L=4 for ROM_LAT=2.
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    cyc();
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    check("hs_e1", hsync, 1);
    cyc();
    check("hs_e2", hsync, 1);
    check("hs2_e2", hsync2, 1);
    cyc();
    check("hs_e3", hsync, 0);
    check("vs_e3", vsync, 0);
    check("hs2_e3", hsync2, 1);
    cyc();
    check("hs_e4", hsync, 1);
    check("hs2_e4", hsync2, 0);
    check("vs2_e4", vsync2, 0);
    cyc();
    check("hs2_e5", hsync2, 1);

    // Reset mid-frame while sprite pixels and low syncs are in flight.
    do_latch(10'd200, 10'd100);
    hsync_in = 1'b0;
    pix(10'd250, 10'd150, 1'b1);
    cyc();
    cyc();
    cyc();
    check("pre_rst_rgb", rgb, 12'hABC);
    rst = 1'b1;
    cyc();
    check("mrst_addr", rom_addr, 0);
    check("mrst_rgb", rgb, 0);
    check("mrst_hsync", hsync, 1);
    check("mrst_tick", frame_tick, 0);
    rst      = 1'b0;
    hsync_in = 1'b1;
    pixel_chk("post_rst_old", 10'd250, 10'd150, 1'b1, 14'd0, 12'h123);
    pixel_chk("post_rst_org", 10'd50, 10'd50, 1'b1, 14'd5050, 12'hABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sprite_pipe.md
Name: vga_sprite_pipe

Overview:
- Pixel-pipeline stage between the 640x480 timing generator and the VGA pins.
- Consumes hsync/vsync/valid/h_cnt/v_cnt plus the requested sprite position from the motion logic.
- Generates the sprite ROM address, absorbs the ROM read latency, and composites sprite pixels over a background colour.
- Emits RGB444 and hsync/vsync delayed by the same amount, so pixels and syncs stay aligned.

Parameters:
- SPR_W, 100, sprite width in pixels.
- SPR_H, 100, sprite height in lines.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ROM_LAT, 1, cycles from rom_addr registered to rom_data valid (1..3).
- ADDR_W, 14, ROM address width; must satisfy SPR_W*SPR_H <= 2^ADDR_W.
- SYNC_IDLE, 1, level of hsync/vsync outputs during reset.

Ports:
- pclk, in, 1, pixel clock.
- rst, in, 1, synchronous active-high reset.
- hsync_in, in, 1, timing-generator hsync.
- vsync_in, in, 1, timing-generator vsync.
- valid_in, in, 1, active-video flag.
- h_cnt, in, 10, pixel column.
- v_cnt, in, 10, line number.
- sprite_x, in, 10, requested sprite left edge.
- sprite_y, in, 10, requested sprite top edge.
- bg_color, in, 12, RGB444 background inside active video.
- rom_addr, out, ADDR_W, sprite ROM address.
- rom_data, in, 12, sprite ROM pixel (RGB444).
- hsync, out, 1, aligned hsync.
- vsync, out, 1, aligned vsync.
- vga_r, out, 4, red.
- vga_g, out, 4, green.
- vga_b, out, 4, blue.
- frame_tick, out, 1, one-cycle pulse when a new position is latched.

Behaviour:
- Reset and clocking
  - All logic is clocked on pclk; rst is synchronous, active-high.
  - During rst: rst wins over every other condition in the same cycle.
  - Reset values: rom_addr=0, vga_r/g/b=0, frame_tick=0, hsync=vsync=SYNC_IDLE, x_l=y_l=0.
  - All delay-line stages take the reset values above; in-area and valid stages reset to 0.
- Position latch
  - Fires on the cycle where v_cnt==V_ACTIVE and h_cnt==0.
  - On that cycle: x_l <= min(sprite_x, H_ACTIVE-SPR_W) and y_l <= min(sprite_y, V_ACTIVE-SPR_H).
  - frame_tick is registered: it is 1 on the cycle after the latch condition, 0 otherwise.
  - Position changes during active video have no effect until the next latch (no tearing).
- Stage 0 (registered at edge 1)
  - in_area = valid_in & (h_cnt >= x_l) & (h_cnt < x_l+SPR_W) & (v_cnt >= y_l) & (v_cnt < y_l+SPR_H).
  - When in_area: rom_addr <= (v_cnt-y_l)*SPR_W + (h_cnt-x_l), computed at ADDR_W bits. The maximum value SPR_W*SPR_H-1 (9999 at defaults) never wraps.
  - When not in_area: rom_addr <= 0.
- Delay lines
  - in_area and valid_in are carried through ROM_LAT+1 register stages.
  - hsync_in and vsync_in are carried through ROM_LAT+2 stages.
  - Total latency L = ROM_LAT+2 cycles from input sample to RGB/sync output (3 at defaults).
- Output stage
  - If delayed valid=0: RGB=0 (blanking is always black).
  - Else if delayed in_area=1: RGB=rom_data.
  - Else: RGB=bg_color.
  - bg_color is sampled at the output stage, not delayed.
- Boundaries
  - Sprite at x_l=0 or y_l=0 is displayed from the first pixel or line.
  - Clamping keeps the sprite fully on-screen; there is no horizontal or vertical wrap.
  - Pixel at h_cnt = x_l+SPR_W is background.
- Reset mid-frame
  - Pipeline is flushed to reset values.
  - The position stays at 0 until the next latch.
  - Outputs follow inputs again L cycles after rst deasserts.

Test Plan:
- Reset: hold rst 5 cycles with active inputs -> rom_addr=0, RGB=0, hsync=vsync=1, frame_tick=0 throughout.
- Latch then first pixel:
  - Drive v_cnt=480, h_cnt=0 with sprite_x=sprite_y=0 -> frame_tick=1 one cycle later.
  - Next frame h=v=0, valid=1 -> rom_addr=0 at edge 1; rom_data=12'hABC -> RGB=A/B/C at edge 3.
- Last sprite pixel: sprite at (200,100), inputs h=299, v=199 -> rom_addr=9999; h=300 -> RGB=bg_color after L=3 cycles.
- Clamp and no-tear:
  - Latch sprite_x=600, sprite_y=470 -> x_l=540, y_l=380.
  - Change sprite_x mid-frame -> the in-area window does not move until the next latch.
- Blanking and sync alignment:
  - valid_in=0 with in-area coordinates -> RGB=0.
  - hsync_in falls at cycle N -> hsync falls at cycle N+3; repeat with ROM_LAT=2 -> N+4.
- Reset mid-frame:
  - Assert rst during active sprite pixels -> outputs at reset values next edge.
  - After release, background appears with the sprite at (0,0) until the next frame_tick.
